// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package if_fetch_pkg;

   localparam logic [31:0] RESET_PC_C = 32'h0000_3000;
   localparam logic [31:0] EXC_PC_C   = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO_C  = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI_C  = 32'h0000_4FFC;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_KILL = 2'd2
   } fetch_state_e;

   // A fetch address is illegal when misaligned or outside the instruction memory window.
   function automatic logic addr_err(input logic [31:0] pc,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
   endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection: exception entry beats exception return beats taken branch beats sequential.
module npc_sel
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] EXC_PC = EXC_PC_C
) (
   input  logic [31:0] pc,
   input  logic        en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        hw_int,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output logic        flush,
   output logic        jump
);

   // Priority mux; a branch only counts when the IF/ID register is accepting.
   always_comb begin
      npc   = pc + 32'd4;
      flush = hw_int | eret;
      jump  = redirect & en;
      if (hw_int) begin
         npc = EXC_PC;
      end else if (eret) begin
         npc = epc;
      end else if (jump) begin
         npc = redirect_pc;
      end else begin
         npc = pc + 32'd4;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: drives the instruction memory, buffers the returned word and
// hands it to IF/ID, dropping responses made stale by redirects and exceptions.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_C,
   parameter logic [31:0] EXC_PC   = EXC_PC_C,
   parameter logic [31:0] IMEM_LO  = IMEM_LO_C,
   parameter logic [31:0] IMEM_HI  = IMEM_HI_C
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        HWInt,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir_f,
   output logic [31:0] pc4_f,
   output logic [31:0] pc_f,
   output logic        valid_f,
   output logic        adel_f
);

   fetch_state_e state_r;
   logic [31:0]  pc_r;
   logic [31:0]  ir_r;
   logic [31:0]  npc_s;
   logic         flush_s;
   logic         jump_s;
   logic         adel_s;
   logic         got_s;
   logic [31:0]  word_s;

   npc_sel #(.EXC_PC(EXC_PC)) u_npc_sel (
      .pc          (pc_r),
      .en          (en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hw_int      (HWInt),
      .eret        (eret),
      .epc         (epc),
      .npc         (npc_s),
      .flush       (flush_s),
      .jump        (jump_s)
   );

   // An illegal address completes at once with a zero word instead of touching memory.
   always_comb begin
      adel_s = addr_err(pc_r, IMEM_LO, IMEM_HI);
      got_s  = adel_s | imem_ready;
      word_s = adel_s ? 32'h0000_0000 : imem_rdata;
   end

   assign imem_addr = pc_r;
   assign pc_f      = pc_r;
   assign pc4_f     = pc_r + 32'd4;

   // Output decode; the returned word is bypassed so IF/ID can take it in the arrival cycle.
   always_comb begin
      imem_req = 1'b0;
      valid_f  = 1'b0;
      adel_f   = 1'b0;
      ir_f     = ir_r;
      if (!clr_n) begin
         ir_f = 32'h0000_0000;
      end else begin
         case (state_r)
            ST_REQ: begin
               imem_req = ~adel_s;
               adel_f   = adel_s;
               valid_f  = got_s & ~flush_s;
               if (got_s) begin
                  ir_f = word_s;
               end else begin
                  ir_f = ir_r;
               end
            end
            ST_HOLD: begin
               valid_f = 1'b1;
               adel_f  = adel_s;
            end
            ST_KILL: begin
               valid_f = 1'b0;
            end
            default: begin
               valid_f = 1'b0;
            end
         endcase
      end
   end

   // Fetch FSM with PC and instruction buffer; reset simply abandons any read in flight.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_PC;
         ir_r    <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_REQ: begin
               if (flush_s) begin
                  pc_r    <= npc_s;
                  state_r <= got_s ? ST_REQ : ST_KILL;
               end else if (got_s) begin
                  ir_r <= word_s;
                  if (en) begin
                     pc_r <= npc_s;
                  end else begin
                     state_r <= ST_HOLD;
                  end
               end else if (jump_s) begin
                  pc_r    <= npc_s;
                  state_r <= ST_KILL;
               end
            end
            ST_HOLD: begin
               if (flush_s || en) begin
                  pc_r    <= npc_s;
                  state_r <= ST_REQ;
               end
            end
            ST_KILL: begin
               // Later redirects still steer the PC while the stale word drains.
               if (flush_s || jump_s) begin
                  pc_r <= npc_s;
               end
               if (imem_ready) begin
                  state_r <= ST_REQ;
               end
            end
            default: begin
               state_r <= ST_REQ;
            end
         endcase
      end
   end

endmodule
